// File: rtl/radix4_butterfly_pipe.sv
// rtl/radix4_butterfly_pipe.sv - pipelined radix-4 DIT butterfly with twiddles, stall, rounding, saturation
module radix4_butterfly_pipe #(
  parameter int DW    = 32,
  parameter int TW    = 16,
  parameter int ROUND = 1,
  parameter int SAT   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_inverse,
  input  logic signed [DW-1:0] a_re,
  input  logic signed [DW-1:0] a_im,
  input  logic signed [DW-1:0] b_re,
  input  logic signed [DW-1:0] b_im,
  input  logic signed [DW-1:0] c_re,
  input  logic signed [DW-1:0] c_im,
  input  logic signed [DW-1:0] d_re,
  input  logic signed [DW-1:0] d_im,
  input  logic signed [TW-1:0] w0_re,
  input  logic signed [TW-1:0] w0_im,
  input  logic signed [TW-1:0] w1_re,
  input  logic signed [TW-1:0] w1_im,
  input  logic signed [TW-1:0] w2_re,
  input  logic signed [TW-1:0] w2_im,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] out0_re,
  output logic signed [DW-1:0] out0_im,
  output logic signed [DW-1:0] out1_re,
  output logic signed [DW-1:0] out1_im,
  output logic signed [DW-1:0] out2_re,
  output logic signed [DW-1:0] out2_im,
  output logic signed [DW-1:0] out3_re,
  output logic signed [DW-1:0] out3_im,
  output logic                 out_ovf
);

  localparam int PW = DW + TW;
  localparam int SW = PW + 1;
  localparam int MW = DW + 2;
  localparam int EW = DW + 4;
  localparam logic signed [SW-1:0] RND = (ROUND != 0) ? (SW'(1) <<< (TW - 2)) : '0;

  logic en;

  logic signed [DW-1:0] x_re [3];
  logic signed [DW-1:0] x_im [3];
  logic signed [TW-1:0] w_re [3];
  logic signed [TW-1:0] w_im [3];

  logic                 s1_valid_q, s1_inv_q;
  logic signed [DW-1:0] s1_a_re_q, s1_a_im_q;
  logic signed [PW-1:0] p_rr_d [3], p_ii_d [3], p_ri_d [3], p_ir_d [3];
  logic signed [PW-1:0] p_rr_q [3], p_ii_q [3], p_ri_q [3], p_ir_q [3];

  logic                 s2_valid_q, s2_inv_q;
  logic signed [DW-1:0] s2_a_re_q, s2_a_im_q;
  logic signed [MW-1:0] m_re_d [3], m_im_d [3];
  logic signed [MW-1:0] m_re_q [3], m_im_q [3];

  logic signed [EW-1:0] t0r, t0i, t1r, t1i, t2r, t2i, t3r, t3i;
  logic signed [EW-1:0] v_re [4], v_im [4];
  logic        [DW-1:0] out_re_d [4], out_im_d [4];
  logic        [DW-1:0] out_re_q [4], out_im_q [4];
  logic                 ovf_d, out_valid_q, out_ovf_q;

  function automatic logic fits(input logic [EW-1:0] v);
    return (&v[EW-1:DW-1]) | ~(|v[EW-1:DW-1]);
  endfunction

  function automatic logic [DW-1:0] narrow(input logic [EW-1:0] v);
    if (SAT != 0 && !fits(v)) return v[EW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    return v[DW-1:0];
  endfunction

  assign en       = !out_valid_q | out_ready;
  assign in_ready = en;

  // S1: twelve raw products, legs b/c/d against w0/w1/w2
  always_comb begin
    x_re = '{b_re, c_re, d_re};
    x_im = '{b_im, c_im, d_im};
    w_re = '{w0_re, w1_re, w2_re};
    w_im = '{w0_im, w1_im, w2_im};
    for (int k = 0; k < 3; k++) begin
      p_rr_d[k] = PW'(x_re[k]) * PW'(w_re[k]);
      p_ii_d[k] = PW'(x_im[k]) * PW'(w_im[k]);
      p_ri_d[k] = PW'(x_re[k]) * PW'(w_im[k]);
      p_ir_d[k] = PW'(x_im[k]) * PW'(w_re[k]);
    end
  end

  // S2: complex sums scaled back to Q0 with optional half-up rounding
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      m_re_d[k] = MW'((SW'(p_rr_q[k]) - SW'(p_ii_q[k]) + RND) >>> (TW - 1));
      m_im_d[k] = MW'((SW'(p_ri_q[k]) + SW'(p_ir_q[k]) + RND) >>> (TW - 1));
    end
  end

  // S3: 4-point DFT at full width, reduced to DW only at the output
  always_comb begin
    t0r = EW'(s2_a_re_q) + EW'(m_re_q[1]);
    t0i = EW'(s2_a_im_q) + EW'(m_im_q[1]);
    t1r = EW'(s2_a_re_q) - EW'(m_re_q[1]);
    t1i = EW'(s2_a_im_q) - EW'(m_im_q[1]);
    t2r = EW'(m_re_q[0]) + EW'(m_re_q[2]);
    t2i = EW'(m_im_q[0]) + EW'(m_im_q[2]);
    t3r = EW'(m_re_q[0]) - EW'(m_re_q[2]);
    t3i = EW'(m_im_q[0]) - EW'(m_im_q[2]);
    v_re[0] = t0r + t2r;
    v_im[0] = t0i + t2i;
    v_re[2] = t0r - t2r;
    v_im[2] = t0i - t2i;
    if (!s2_inv_q) begin
      v_re[1] = t1r + t3i;
      v_im[1] = t1i - t3r;
      v_re[3] = t1r - t3i;
      v_im[3] = t1i + t3r;
    end else begin
      v_re[1] = t1r - t3i;
      v_im[1] = t1i + t3r;
      v_re[3] = t1r + t3i;
      v_im[3] = t1i - t3r;
    end
    ovf_d = 1'b0;
    for (int k = 0; k < 4; k++) begin
      out_re_d[k] = narrow(v_re[k]);
      out_im_d[k] = narrow(v_im[k]);
      ovf_d = ovf_d | !fits(v_re[k]) | !fits(v_im[k]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_inv_q    <= 1'b0;
      s1_a_re_q   <= '0;
      s1_a_im_q   <= '0;
      p_rr_q      <= '{default: '0};
      p_ii_q      <= '{default: '0};
      p_ri_q      <= '{default: '0};
      p_ir_q      <= '{default: '0};
      s2_valid_q  <= 1'b0;
      s2_inv_q    <= 1'b0;
      s2_a_re_q   <= '0;
      s2_a_im_q   <= '0;
      m_re_q      <= '{default: '0};
      m_im_q      <= '{default: '0};
      out_valid_q <= 1'b0;
      out_ovf_q   <= 1'b0;
      out_re_q    <= '{default: '0};
      out_im_q    <= '{default: '0};
    end else if (en) begin
      s1_valid_q  <= in_valid;
      s1_inv_q    <= in_inverse;
      s1_a_re_q   <= a_re;
      s1_a_im_q   <= a_im;
      p_rr_q      <= p_rr_d;
      p_ii_q      <= p_ii_d;
      p_ri_q      <= p_ri_d;
      p_ir_q      <= p_ir_d;
      s2_valid_q  <= s1_valid_q;
      s2_inv_q    <= s1_inv_q;
      s2_a_re_q   <= s1_a_re_q;
      s2_a_im_q   <= s1_a_im_q;
      m_re_q      <= m_re_d;
      m_im_q      <= m_im_d;
      out_valid_q <= s2_valid_q;
      out_ovf_q   <= ovf_d;
      out_re_q    <= out_re_d;
      out_im_q    <= out_im_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_ovf   = out_ovf_q;
  assign out0_re   = out_re_q[0];
  assign out0_im   = out_im_q[0];
  assign out1_re   = out_re_q[1];
  assign out1_im   = out_im_q[1];
  assign out2_re   = out_re_q[2];
  assign out2_im   = out_im_q[2];
  assign out3_re   = out_re_q[3];
  assign out3_im   = out_im_q[3];

endmodule
